// File: rtl/pingpong_frame_loader.sv
// Ping-pong frame buffer: fills one bank from a strobe-driven word source while
// the other, completed bank drains to the display over valid/ready.
module pingpong_frame_loader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 200,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] WData,
  output logic              WE0,
  output logic              WE1,
  input  logic              rd_ready,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              frame_start,
  output logic              rd_bank,
  output logic              underrun
);
  // state  | meaning
  // W_IDLE | strobes low; launch a fill when wr_bank is free and not being drained
  // W_FILL | strobe high DEPTH cycles; the last word lands on the exit edge,
  //        | which also marks the bank full and toggles wr_bank
  // R_IDLE | wait for full[rd_bank]
  // R_LOAD | fetch word 0 of the bank into pix_data
  // R_SHOW | present pix_data; advance on rd_ready, release bank after word DEPTH-1
  typedef enum logic       {W_IDLE, W_FILL}         wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SHOW} rstate_t;

  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [2][DEPTH];

  wstate_t           r_wstate, w_wstate_nxt;
  rstate_t           r_rstate, w_rstate_nxt;
  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_we0, r_we1;
  logic [1:0]        r_full;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_pix_valid;
  logic [DATA_W-1:0] r_pix_data;
  logic              r_seen_frame;
  logic              r_underrun;

  logic              w_launch, w_fill_last, w_capture;
  logic              w_rd_busy, w_accept, w_rd_last;
  logic [ADDR_W-1:0] w_rd_addr_inc;
  logic [1:0]        w_full_set, w_full_clr;

  assign w_capture     = r_we0 | r_we1;
  assign w_rd_busy     = (r_rstate == R_LOAD) || (r_rstate == R_SHOW);
  assign w_accept      = (r_rstate == R_SHOW) && rd_ready;
  assign w_rd_last     = w_accept && (r_rd_addr == LAST);
  assign w_rd_addr_inc = r_rd_addr + ADDR_W'(1);
  assign w_full_set    = {w_fill_last & r_wr_bank, w_fill_last & ~r_wr_bank};
  assign w_full_clr    = {w_rd_last & r_rd_bank, w_rd_last & ~r_rd_bank};

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_launch     = 1'b0;
    w_fill_last  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (!r_full[r_wr_bank] && !(w_rd_busy && (r_rd_bank == r_wr_bank))) begin
          w_launch     = 1'b1;
          w_wstate_nxt = W_FILL;
        end
      end
      W_FILL: begin
        if (r_wr_addr == LAST) begin
          w_fill_last  = 1'b1;
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_bank <= 1'b0;
      r_wr_addr <= '0;
      r_we0     <= 1'b0;
      r_we1     <= 1'b0;
    end else if (w_launch) begin
      r_wr_addr <= '0;
      r_we0     <= ~r_wr_bank;
      r_we1     <= r_wr_bank;
    end else if (w_capture) begin
      r_wr_addr <= r_wr_addr + ADDR_W'(1);
      if (w_fill_last) begin
        r_we0     <= 1'b0;
        r_we1     <= 1'b0;
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Bank contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (w_capture) r_mem[r_wr_bank][r_wr_addr[IDX_W-1:0]] <= WData;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_full <= 2'b00;
    else       r_full <= (r_full | w_full_set) & ~w_full_clr;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (r_full[r_rd_bank]) w_rstate_nxt = R_LOAD;
      R_LOAD:  w_rstate_nxt = R_SHOW;
      R_SHOW:  if (w_rd_last) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_bank   <= 1'b0;
      r_rd_addr   <= '0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
    end else if (r_rstate == R_LOAD) begin
      r_rd_addr   <= '0;
      r_pix_valid <= 1'b1;
      r_pix_data  <= r_mem[r_rd_bank][0];
    end else if (w_rd_last) begin
      r_rd_addr   <= '0;
      r_pix_valid <= 1'b0;
      r_rd_bank   <= ~r_rd_bank;
    end else if (w_accept) begin
      r_rd_addr  <= w_rd_addr_inc;
      r_pix_data <= r_mem[r_rd_bank][w_rd_addr_inc[IDX_W-1:0]];
    end
  end

  // Underrun only counts once the display has seen a first frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seen_frame <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (frame_start) r_seen_frame <= 1'b1;
      if (r_seen_frame && rd_ready && !r_pix_valid) r_underrun <= 1'b1;
    end
  end

  assign WE0         = r_we0;
  assign WE1         = r_we1;
  assign pix_valid   = r_pix_valid;
  assign pix_data    = r_pix_data;
  assign frame_start = r_pix_valid && (r_rd_addr == '0);
  assign rd_bank     = r_rd_bank;
  assign underrun    = r_underrun;

endmodule
